// File: rtl/calc_pkg.sv
// Shared definitions for the remainder calculator front end.
package calc_pkg;

  localparam int OPERAND_W        = 3;
  localparam int SIGN_BIT         = 2;
  localparam int MAG_W            = 2;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_NUM  = 2'd0,
    S_DEN  = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counting debouncer and a
// one-cycle pulse on the rising edge of the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             level_q;
  logic             level_d;
  logic             press_q;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Toggle the level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (sync_p1 == level_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      level_q <= ~level_q;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered single-cycle pulse on the debounced rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      press_q <= 1'b0;
    end else begin
      level_d <= level_q;
      press_q <= level_q & ~level_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/rem_operand_sequencer.sv
// Operand capture sequencer for the combinational remainder unit: numerator
// and denominator are entered one debounced press each, the unit's outputs
// are registered once and held for display.
module rem_operand_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] sw_value,
  input  logic                 enter,
  input  logic                 clear,
  output logic [OPERAND_W-1:0] numerator,
  output logic [OPERAND_W-1:0] denominator,
  input  logic [OPERAND_W-1:0] rem_remainder,
  input  logic                 rem_divbyzero,
  output logic [OPERAND_W-1:0] result,
  output logic                 error,
  output logic                 result_valid,
  output logic [1:0]           state_o
);

  state_t               state;
  state_t               state_next;
  logic [OPERAND_W-1:0] num_next;
  logic [OPERAND_W-1:0] den_next;
  logic [OPERAND_W-1:0] res_next;
  logic                 err_next;
  logic                 vld_next;
  logic                 press;
  logic                 enter_level;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_enter_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (enter),
    .level(enter_level),
    .press(press)
  );

  // State and all visible registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_NUM;
      numerator    <= '0;
      denominator  <= '0;
      result       <= '0;
      error        <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      numerator    <= num_next;
      denominator  <= den_next;
      result       <= res_next;
      error        <= err_next;
      result_valid <= vld_next;
    end
  end

  // Next-state and register updates; clear overrides any press.
  always_comb begin
    state_next = state;
    num_next   = numerator;
    den_next   = denominator;
    res_next   = result;
    err_next   = error;
    vld_next   = result_valid;
    if (clear) begin
      state_next = S_NUM;
      num_next   = '0;
      den_next   = '0;
      res_next   = '0;
      err_next   = 1'b0;
      vld_next   = 1'b0;
    end else begin
      case (state)
        S_NUM: begin
          if (press) begin
            num_next   = sw_value;
            state_next = S_DEN;
          end
        end
        S_DEN: begin
          if (press) begin
            den_next   = sw_value;
            state_next = S_CALC;
          end
        end
        S_CALC: begin
          // Operands are registers, so the remainder unit has settled here.
          res_next   = rem_remainder;
          err_next   = rem_divbyzero;
          vld_next   = 1'b1;
          state_next = S_SHOW;
        end
        S_SHOW: begin
          // Chained entry: new numerator, old denominator stays visible.
          if (press) begin
            num_next   = sw_value;
            vld_next   = 1'b0;
            state_next = S_DEN;
          end
        end
        default: state_next = S_NUM;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_rem_operand_sequencer.sv
// Directed bench for rem_operand_sequencer with a behavioural remainder unit.
module tb_rem_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_value;
  logic       enter;
  logic       clear;
  logic [2:0] numerator;
  logic [2:0] denominator;
  logic [2:0] rem_remainder;
  logic       rem_divbyzero;
  logic [2:0] result;
  logic       error;
  logic       result_valid;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] res;
    logic       err;
  } exp_t;
  exp_t sbq[$];

  rem_operand_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_value     (sw_value),
    .enter        (enter),
    .clear        (clear),
    .numerator    (numerator),
    .denominator  (denominator),
    .rem_remainder(rem_remainder),
    .rem_divbyzero(rem_divbyzero),
    .result       (result),
    .error        (error),
    .result_valid (result_valid),
    .state_o      (state_o)
  );

  // Signed-magnitude remainder unit: sign follows numerator.
  assign rem_divbyzero = (denominator[1:0] == 2'b00);
  assign rem_remainder = rem_divbyzero ? {numerator[2], 2'b00}
                                       : {numerator[2], numerator[1:0] % denominator[1:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 8'(state_o), 8'd0);
    chk({tag, "_num"}, 8'(numerator), 8'd0);
    chk({tag, "_den"}, 8'(denominator), 8'd0);
    chk({tag, "_res"}, 8'(result), 8'd0);
    chk({tag, "_err"}, 8'(error), 8'd0);
    chk({tag, "_vld"}, 8'(result_valid), 8'd0);
  endtask

  // Raise enter with sw_value and wait (bounded) for the first state change.
  task automatic press_wait(input logic [2:0] v, output logic [1:0] ns, output int n);
    logic [1:0] s0;
    s0 = state_o;
    sw_value = v;
    enter = 1'b1;
    n = 0;
    ns = s0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (state_o !== s0) begin
        ns = state_o;
        n = i;
        break;
      end
    end
    if (n == 0) chk("press_timeout", 8'(n), 8'd8);
  endtask

  task automatic release_btn();
    enter = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    chk({tag, "_vld"}, 8'(result_valid), 8'd1);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'(sbq.size()), 8'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_res"}, 8'(result), 8'(e.res));
      chk({tag, "_err"}, 8'(error), 8'(e.err));
    end
  endtask

  // Press in S_DEN: S_CALC next cycle, result valid the cycle after.
  task automatic calc_press(input string tag, input logic [2:0] v, input exp_t e);
    logic [1:0] ns;
    int n;
    sbq.push_back(e);
    press_wait(v, ns, n);
    chk({tag, "_calc_state"}, 8'(ns), 8'd2);
    chk({tag, "_calc_vld"}, 8'(result_valid), 8'd0);
    @(negedge clk);
    chk({tag, "_show_state"}, 8'(state_o), 8'd3);
    pop_cmp(tag);
    chk({tag, "_den"}, 8'(denominator), 8'(v));
    release_btn();
  endtask

  initial begin
    logic [1:0] ns;
    int n;
    int changes;
    logic [1:0] prev;

    rst_n = 1'b0;
    sw_value = '0;
    enter = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 011 then 010 -> remainder 001; press latency from enter edge.
    press_wait(3'b011, ns, n);
    chk("num_press_latency", 8'(n), 8'd8);
    chk("num_state", 8'(ns), 8'd1);
    repeat (15) @(negedge clk);
    chk("hold_no_repress", 8'(state_o), 8'd1);
    release_btn();
    chk("release_no_press", 8'(state_o), 8'd1);
    chk("num_011", 8'(numerator), 8'h3);
    calc_press("rem_3_2", 3'b010, '{res: 3'b001, err: 1'b0});
    chk("num_held", 8'(numerator), 8'h3);

    // Chained entry from S_SHOW.
    press_wait(3'b111, ns, n);
    chk("chain_state", 8'(ns), 8'd1);
    chk("chain_vld", 8'(result_valid), 8'd0);
    chk("chain_num", 8'(numerator), 8'h7);
    chk("chain_old_den", 8'(denominator), 8'h2);
    release_btn();
    calc_press("rem_m3_2", 3'b010, '{res: 3'b101, err: 1'b0});

    // Clear from S_SHOW, then divide by negative-sign zero operand path.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_zero("clear_show");
    press_wait(3'b101, ns, n);
    chk("dz_num_state", 8'(ns), 8'd1);
    release_btn();
    calc_press("divzero", 3'b000, '{res: 3'b100, err: 1'b1});

    // Glitch then bounce then hold: exactly one advance 0->1.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    changes = 0;
    prev = state_o;
    sw_value = 3'b110;
    for (int i = 0; i < 32; i++) begin
      enter = (i < 3) || (i == 5) || (i == 7) || (i >= 9 && i < 29);
      @(negedge clk);
      if (state_o !== prev) changes++;
      prev = state_o;
    end
    enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_changes", 8'(changes), 8'd1);
    chk("glitch_state", 8'(state_o), 8'd1);
    chk("glitch_num", 8'(numerator), 8'h6);

    // Clear in the same cycle as the S_DEN press (press acts at edge t+7).
    sw_value = 3'b011;
    enter = 1'b1;
    repeat (7) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_zero("clear_vs_press");
    repeat (10) @(negedge clk);
    chk("clear_no_capture", 8'(state_o), 8'd0);
    release_btn();

    // Asynchronous reset in S_DEN, checked before any clock edge.
    press_wait(3'b011, ns, n);
    chk("rst_pre_state", 8'(ns), 8'd1);
    release_btn();
    chk("rst_pre_num", 8'(numerator), 8'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rem_operand_sequencer.md
Name: rem_operand_sequencer

Overview:
- Front-end stage that feeds the combinational remainder unit from board switches and an Enter push-button.
- Captures a 3-bit signed-magnitude numerator, then a denominator, one debounced press each.
- Drives both operands to the remainder unit, registers its remainder and divide-by-zero outputs, and holds them for display.
- Operand format: bit 2 = sign, bits 1:0 = magnitude.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples required before the debounced button level changes.
- CNT_W, 3: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_value  input  3  operand from switches (sign, magnitude[1:0]); sampled only on an accepted press.
- enter  input  1  raw, asynchronous, bouncy Enter button (active-high).
- clear  input  1  synchronous clear (already synchronous to clk), active-high.
- numerator  output  3  registered numerator driven to the remainder unit.
- denominator  output  3  registered denominator driven to the remainder unit.
- rem_remainder  input  3  remainder returned by the remainder unit (combinational from numerator/denominator).
- rem_divbyzero  input  1  divide-by-zero flag returned by the remainder unit.
- result  output  3  held remainder for display.
- error  output  1  held divide-by-zero flag.
- result_valid  output  1  result/error hold a completed calculation.
- state_o  output  2  current state encoding, for LEDs.

Behaviour:
- Reset (async, rst_n=0):
  - state = S_NUM; numerator, denominator, result = 3'b000; error, result_valid = 0.
  - Synchroniser and debounce state cleared; debounced level = 0.
  - Reset is effective immediately, including mid-calculation.
- Button path:
  - enter passes through a 2-flop synchroniser.
  - The counter increments while the synchronised sample differs from the debounced level, and resets to 0 on equality.
  - When the counter reaches DEBOUNCE_CYCLES-1 the level toggles and the counter clears.
  - press = one-cycle pulse on the debounced level's rising edge.
  - Clean enter rising at edge t gives press high during cycle t+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES give no press. Holding enter gives exactly one press; release gives none.
- State encoding: S_NUM=0, S_DEN=1, S_CALC=2, S_SHOW=3.
- S_NUM: on press, numerator <= sw_value; go to S_DEN.
- S_DEN: on press, denominator <= sw_value; go to S_CALC.
- S_CALC (exactly one cycle; press ignored):
  - result <= rem_remainder, error <= rem_divbyzero, result_valid <= 1; go to S_SHOW.
  - Operands are stable registers, so the combinational remainder is settled.
- S_SHOW:
  - Hold all outputs.
  - On press: numerator <= sw_value, result_valid <= 0, go to S_DEN. The chained calculation keeps the old denominator visible until overwritten.
- clear=1 in any state: same values as reset, applied synchronously. clear wins over a simultaneous press.
- Latency: press in S_DEN at cycle k → S_CALC in cycle k+1 → result_valid=1 and result stable from cycle k+2.
- Divide-by-zero: denominator[1:0]=00, including sign-1 "negative zero". error=1 and result is whatever the remainder unit reports (sign propagated, magnitude 00). The sequencer does not second-guess it.
- The sequencer performs no arithmetic; all outputs are registered.

Decomposition:
- Shared package calc_pkg holds:
  - state typedef and encodings S_NUM..S_SHOW;
  - OPERAND_W=3, SIGN_BIT=2, MAG_W=2;
  - DEBOUNCE_DEFAULT=4.
- One natural sub-module: button_debounce (synchroniser, counter, rising-edge pulse), parameterised by DEBOUNCE_CYCLES. It is reused for any further board buttons.
- The remainder unit is instantiated beside this block at top level, not inside it.

Test Plan:
- Reset mid-S_DEN with numerator=3'b011 → all outputs 0, state_o=0 immediately, without waiting for a clock edge.
- Enter 3'b011 then 3'b010, with a real remainder unit attached → numerator=011, denominator=010; result=3'b001, error=0, result_valid=1 exactly 2 cycles after the second press.
- Enter 3'b101 then 3'b000 → error=1, result=3'b100, result_valid=1.
- Enter pulse of DEBOUNCE_CYCLES-1 cycles, then bounce (1,0,1,0) before holding 20 cycles → exactly one state advance; state_o 0→1 only.
- In S_SHOW, press with sw_value=3'b111 → result_valid=0, numerator=111, state_o=1. Then press with 3'b010 → result=3'b101, error=0.
- clear asserted in the same cycle as a press in S_DEN → state_o=0, all registers 0, no operand captured.
